// File: rtl/sub_float.sv
// sub_float: sequential IEEE-754 binary32 subtractor (diff = a - b).
// Alignment and normalization move one bit per cycle to keep the datapath narrow.
// Denormal inputs are flushed to zero. Results that underflow become a signed zero.
module sub_float (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] diff
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;

  state_t      state_reg, state_next;
  logic        sign_reg, sign_next;        // sign of the larger operand L
  logic        eff_sub_reg, eff_sub_next;  // effective signs differ
  logic [8:0]  exp_reg, exp_next;          // wide enough to hold 255 plus a carry
  logic [26:0] mant_l_reg, mant_l_next;    // {1, frac, G, R, S}
  logic [26:0] mant_s_reg, mant_s_next;
  logic [27:0] sum_reg, sum_next;          // bit 27 is the add carry
  logic [4:0]  cnt_reg, cnt_next;          // remaining alignment shifts
  logic [31:0] diff_reg, diff_next;

  // Operand fields. The subtrahend sign is inverted so everything after this is an add.
  logic [7:0]  exp_a, exp_b;
  logic        sign_a, sign_b;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic        a_ge_b;
  logic [7:0]  exp_big, exp_small, exp_diff;
  logic [4:0]  cnt_init;
  logic [26:0] mant_a, mant_b;

  assign exp_a  = a[30:23];
  assign exp_b  = b[30:23];
  assign sign_a = a[31];
  assign sign_b = ~b[31];
  assign a_nan  = (exp_a == 8'hFF) && (a[22:0] != 23'd0);
  assign b_nan  = (exp_b == 8'hFF) && (b[22:0] != 23'd0);
  assign a_inf  = (exp_a == 8'hFF) && (a[22:0] == 23'd0);
  assign b_inf  = (exp_b == 8'hFF) && (b[22:0] == 23'd0);
  assign a_zero = (exp_a == 8'd0);
  assign b_zero = (exp_b == 8'd0);
  assign a_ge_b = (a[30:0] >= b[30:0]);
  assign mant_a = {1'b1, a[22:0], 3'b000};
  assign mant_b = {1'b1, b[22:0], 3'b000};
  assign exp_big   = a_ge_b ? exp_a : exp_b;
  assign exp_small = a_ge_b ? exp_b : exp_a;
  assign exp_diff  = exp_big - exp_small;
  // Beyond 27 shifts every bit of S has already collapsed into sticky.
  assign cnt_init  = (exp_diff > 8'd27) ? 5'd27 : exp_diff[4:0];

  // Special operand combinations that bypass the datapath entirely.
  logic        is_special;
  logic [31:0] special_val;

  // Resolve NaN / Inf / zero / exact-cancellation cases at accept time.
  always_comb begin
    is_special  = 1'b1;
    special_val = 32'd0;
    if (a_nan || b_nan) begin
      special_val = QNAN;
    end else if (a_inf && b_inf) begin
      special_val = (sign_a == sign_b) ? {sign_a, 8'hFF, 23'd0} : QNAN;
    end else if (a_inf) begin
      special_val = {sign_a, 8'hFF, 23'd0};
    end else if (b_inf) begin
      special_val = {sign_b, 8'hFF, 23'd0};
    end else if (a_zero && b_zero) begin
      special_val = {sign_a & sign_b, 31'd0};
    end else if (b_zero) begin
      special_val = a;
    end else if (a_zero) begin
      special_val = {~b[31], b[30:0]};
    end else if ((a[30:0] == b[30:0]) && (sign_a != sign_b)) begin
      special_val = 32'd0;
    end else begin
      is_special = 1'b0;
    end
  end

  // Round to nearest even on G/R/S; a carry out leaves rounded = 2^24.
  logic        round_up;
  logic [24:0] rounded;
  logic [8:0]  exp_rnd;
  logic [22:0] frac_rnd;

  assign round_up = sum_reg[2] & (sum_reg[1] | sum_reg[0] | sum_reg[3]);
  assign rounded  = {1'b0, sum_reg[26:3]} + {24'd0, round_up};
  assign exp_rnd  = exp_reg + {8'd0, rounded[24]};
  assign frac_rnd = rounded[24] ? rounded[23:1] : rounded[22:0];

  // Next-state and datapath updates; every register holds unless its state acts on it.
  always_comb begin
    state_next   = state_reg;
    sign_next    = sign_reg;
    eff_sub_next = eff_sub_reg;
    exp_next     = exp_reg;
    mant_l_next  = mant_l_reg;
    mant_s_next  = mant_s_reg;
    sum_next     = sum_reg;
    cnt_next     = cnt_reg;
    diff_next    = diff_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          if (is_special) begin
            diff_next  = special_val;
            state_next = DONE;
          end else begin
            sign_next    = a_ge_b ? sign_a : sign_b;
            eff_sub_next = sign_a ^ sign_b;
            exp_next     = {1'b0, exp_big};
            mant_l_next  = a_ge_b ? mant_a : mant_b;
            mant_s_next  = a_ge_b ? mant_b : mant_a;
            cnt_next     = cnt_init;
            state_next   = ALIGN;
          end
        end
      end
      ALIGN: begin
        if (cnt_reg == 5'd0) begin
          state_next = ADD;
        end else begin
          mant_s_next = {1'b0, mant_s_reg[26:2], mant_s_reg[1] | mant_s_reg[0]};
          cnt_next    = cnt_reg - 5'd1;
        end
      end
      ADD: begin
        if (eff_sub_reg) begin
          sum_next = {1'b0, mant_l_reg} - {1'b0, mant_s_reg};
        end else begin
          sum_next = {1'b0, mant_l_reg} + {1'b0, mant_s_reg};
        end
        state_next = NORM;
      end
      NORM: begin
        if (sum_reg[27]) begin
          sum_next   = {1'b0, sum_reg[27:2], sum_reg[1] | sum_reg[0]};
          exp_next   = exp_reg + 9'd1;
          state_next = ROUND;
        end else if (!sum_reg[26] && (exp_reg > 9'd1)) begin
          sum_next = {sum_reg[26:0], 1'b0};
          exp_next = exp_reg - 9'd1;
        end else if (!sum_reg[26]) begin
          diff_next  = {sign_reg, 31'd0};
          state_next = DONE;
        end else begin
          state_next = ROUND;
        end
      end
      ROUND: begin
        if (exp_rnd >= 9'd255) begin
          diff_next = {sign_reg, 8'hFF, 23'd0};
        end else begin
          diff_next = {sign_reg, exp_rnd[7:0], frac_rnd};
        end
        state_next = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything and drops any in-flight result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      sign_reg    <= 1'b0;
      eff_sub_reg <= 1'b0;
      exp_reg     <= 9'd0;
      mant_l_reg  <= 27'd0;
      mant_s_reg  <= 27'd0;
      sum_reg     <= 28'd0;
      cnt_reg     <= 5'd0;
      diff_reg    <= 32'd0;
    end else begin
      state_reg   <= state_next;
      sign_reg    <= sign_next;
      eff_sub_reg <= eff_sub_next;
      exp_reg     <= exp_next;
      mant_l_reg  <= mant_l_next;
      mant_s_reg  <= mant_s_next;
      sum_reg     <= sum_next;
      cnt_reg     <= cnt_next;
      diff_reg    <= diff_next;
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign diff      = diff_reg;

endmodule

// File: doc/sub_float.md
# sub_float

Multi-cycle IEEE-754 single-precision subtractor computing `diff = a - b` with valid/ready handshakes on both sides. It is the inverse-direction companion to the combinational float adder in the ALU datapath: the same operand formats, with the opposite operation. It is sequenced by a state machine: alignment and normalization shift one bit per cycle, which trades latency for a small datapath. It sits beside the adder in the floating-point unit and is selected by the ALU for FSUB operations.

## Interface
Parameters:
- none; the format is fixed at binary32 (1 sign, 8 exponent, 23 fraction bits)

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  reset, synchronous and active-high
- `in_valid`  in  1  operands present on `a`, `b`
- `in_ready`  out  1  high only in IDLE
- `a`  in  32  minuend, IEEE-754 single
- `b`  in  32  subtrahend, IEEE-754 single
- `out_valid`  out  1  `diff` valid; high only in DONE
- `out_ready`  in  1  consumer accepts `diff`
- `diff`  out  32  result, IEEE-754 single

## Operation
- **States:** IDLE, ALIGN, ADD, NORM, ROUND, DONE.
- **Accept:** an operand pair is accepted when `in_valid && in_ready`. Operands are registered; `a` and `b` may change afterwards.
- **Unpack (at accept):**
  - Effective sign of b = `~b[31]`.
  - Exponent 0 is treated as zero; denormals are flushed to zero and their sign is kept.
  - A normal mantissa is `{1, frac, 3'b000}`, i.e. 27 bits including guard, round and sticky (GRS).
- **Specials (resolved at accept, go straight to DONE):**
  - Either operand is NaN -> `32'h7FC00000`.
  - Inf - Inf with the same sign -> `32'h7FC00000`.
  - Any other case with an Inf operand -> that infinity, with its effective sign.
  - Both operands zero -> `+0`, except `(-0) - (+0)` -> `32'h80000000`.
  - `b` zero -> `a`.
  - `a` zero -> `b` with its sign flipped.
  - Equal magnitude with effective subtraction -> `+0`.
- **Swap:** the larger magnitude, compared as `{exp, frac}`, becomes operand L; the other becomes S.
  - Result sign = sign of L.
  - `d = expL - expS`.
- **ALIGN:** one action per cycle.
  - If the remaining count is 0, go to ADD.
  - Otherwise shift S right by 1, OR the shifted-out bit into sticky, and decrement the count.
  - The count is preloaded with `min(d, 27)`. For `d > 27`, S is reduced to sticky only.
- **ADD:** one cycle, 28-bit result.
  - Same effective signs: `L + S`.
  - Otherwise: `L - S`.
- **NORM:** one action per cycle, checked in this order.
  - Bit 27 set: shift right 1, keeping sticky; exponent + 1; go to ROUND.
  - Bit 26 clear and exponent > 1: shift left 1; exponent - 1.
  - Bit 26 clear and exponent <= 1: underflow; result is a signed zero; go to DONE.
  - Otherwise: go to ROUND.
- **ROUND:** round to nearest, ties to even, on the GRS bits.
  - If mantissa rounding carries out, exponent + 1 and the mantissa becomes `1.0`.
  - If the exponent reaches 255, the result is a signed infinity (`7F800000` / `FF800000`).
  - The result is then packed and the state goes to DONE.
- **DONE:** `out_valid` = 1, with `diff` held stable. On `out_ready`, go to IDLE.

## Timing
- **Reset values:**
  - State = IDLE.
  - `in_ready` = 1 from the first cycle after reset.
  - `out_valid` = 0.
  - `diff` = `32'h00000000`.
  - All internal registers are cleared.
- **Latency** (cycles after the accept edge until `out_valid` is high):
  - Special cases: 1 cycle.
  - Normal path: `min(d,27) + n + 5` cycles, where n = number of left shifts in NORM.
- **Throughput:** one operation in flight. `in_ready` = 0 from the accept edge until the DONE handshake.
- **Handshake edge:** the earliest next accept is the cycle after `out_valid && out_ready`. `in_ready` returns in that same next cycle. There is no combinational path from `out_ready` to `in_ready`.
- **Backpressure:** DONE holds indefinitely while `out_ready` = 0, and `diff` must not change.
- **Reset mid-operation:** `rst` in any state returns to IDLE on that edge. `out_valid` falls and the in-flight result is discarded.
- **Simultaneous events:** `in_valid` asserted while not in IDLE is ignored, with no side effects. `rst` has priority over every handshake.

## Test plan
- **3.0 - 1.0:** `a=40400000`, `b=3F800000` -> `diff=40000000`, with `out_valid` 6 cycles after accept (d=1, n=0).
- **Opposite signs:** `3F800000 - BF800000` -> `40000000` via the carry path, 5 cycles.
- **Exact cancellation:** `3F800000 - 3F800000` -> `00000000` after 1 cycle.
- **Sticky/rounding:**
  - `3F800000 - 30800000` (1 - 2^-30) -> `3F800000`. Expected path: d capped at 27, n=1, rounding carry; latency 33.
  - `7F7FFFFF - FF7FFFFF` -> `7F800000`.
- **Specials:**
  - `7FC00000 - 3F800000` -> `7FC00000`.
  - `7F800000 - 7F800000` -> `7FC00000`.
  - `00000000 - 40000000` -> `C0000000`, each after 1 cycle.
- **Control:**
  - Hold `out_ready=0` for 10 cycles in DONE: `diff` and `out_valid` stay stable and `in_ready=0`.
  - Assert `rst` during ALIGN of a d=20 operation: the next cycle shows `out_valid=0` and `in_ready=1`.
  - A new operation then completes correctly.
